// File: rtl/cache_wb_nway.sv
// N-way set-associative write-back, write-allocate data cache with true-LRU replacement.
// The memory side is a word-serial burst port: one beat per MemAck, with writeback beats sent before refill beats.
module cache_wb_nway #(
    parameter int ADDR_W    = 10,
    parameter int WORD_W    = 32,
    parameter int BLK_WORDS = 4,
    parameter int SETS      = 4,
    parameter int WAYS      = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cpu_req,
    input  logic              i_read_or_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WORD_W-1:0] i_write_data,
    output logic [WORD_W-1:0] o_read_data,
    output logic              o_cpu_ready,
    output logic              o_hit_or_miss,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [WORD_W-1:0] o_mem_wdata,
    input  logic [WORD_W-1:0] i_mem_rdata,
    input  logic              i_mem_ack
);

    localparam int OFF_W   = $clog2(BLK_WORDS);
    localparam int IDX_W   = (SETS > 1) ? $clog2(SETS) : 0;
    localparam int IDX_WS  = (SETS > 1) ? IDX_W : 1;
    localparam int TAG_LSB = 2 + OFF_W + IDX_W;
    localparam int TAG_W   = ADDR_W - TAG_LSB;
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WB, S_REFILL, S_RESP} state_t;

    logic [WORD_W-1:0] r_data  [SETS][WAYS][BLK_WORDS];
    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [WAYS-1:0]   r_valid [SETS];
    logic [WAYS-1:0]   r_dirty [SETS];
    logic [WAY_W-1:0]  r_age   [SETS][WAYS];

    state_t            r_state;
    state_t            w_state_nxt;
    logic [OFF_W-1:0]  r_beat;
    logic [WAY_W-1:0]  r_victim;
    logic [WORD_W-1:0] r_rdata;
    logic              r_hit;

    logic [OFF_W-1:0]  w_off;
    logic [IDX_WS-1:0] w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [1:0]        w_unused_addr_bits;

    assign w_off              = i_addr[OFF_W+1:2];
    assign w_tag              = i_addr[ADDR_W-1 -: TAG_W];
    assign w_unused_addr_bits = i_addr[1:0];

    generate
        if (SETS > 1) begin : g_idx
            assign w_idx = i_addr[OFF_W+2 +: IDX_W];
        end else begin : g_no_idx
            assign w_idx = '0;
        end
    endgenerate

    logic             w_hit;
    logic [WAY_W-1:0] w_hit_way;
    logic             w_found_inv;
    logic [WAY_W-1:0] w_victim;
    logic [WAY_W-1:0] w_max_age;

    // NOTE: every signal driven from always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_found_inv = 1'b0;
        w_victim    = '0;
        w_max_age   = r_age[w_idx][0];
        for (int w = 0; w < WAYS; w++) begin
            if (!w_hit && r_valid[w_idx][w] && r_tag[w_idx][w] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (!w_found_inv && !r_valid[w_idx][w]) begin
                w_found_inv = 1'b1;
                w_victim    = WAY_W'(w);
            end
        end
        // With every way valid, the victim is the lowest-index way holding the maximum age.
        if (!w_found_inv) begin
            for (int w = 1; w < WAYS; w++) begin
                if (r_age[w_idx][w] > w_max_age) begin
                    w_max_age = r_age[w_idx][w];
                    w_victim  = WAY_W'(w);
                end
            end
        end
    end

    logic              w_last;
    logic              w_miss_start;
    logic              w_hit_acc;
    logic              w_refill_we;
    logic              w_fill_done;
    logic              w_acc_en;
    logic [WAY_W-1:0]  w_acc_way;
    logic [ADDR_W-1:0] w_base;

    assign w_last       = (r_beat == OFF_W'(BLK_WORDS - 1));
    assign w_hit_acc    = (r_state == S_IDLE) && i_cpu_req && w_hit;
    assign w_miss_start = (r_state == S_IDLE) && i_cpu_req && !w_hit;
    assign w_refill_we  = (r_state == S_REFILL) && i_mem_ack;
    assign w_fill_done  = w_refill_we && w_last;
    assign w_acc_en     = w_hit_acc || w_fill_done;
    assign w_acc_way    = w_hit_acc ? w_hit_way : r_victim;
    assign w_base       = (ADDR_W'(w_idx) << (OFF_W + 2)) | (ADDR_W'(r_beat) << 2);

    always_comb begin
        w_state_nxt   = r_state;
        o_cpu_ready   = 1'b0;
        o_hit_or_miss = 1'b0;
        o_mem_req     = 1'b0;
        o_mem_we      = 1'b0;
        o_mem_addr    = '0;
        o_mem_wdata   = '0;
        unique case (r_state)
            S_IDLE: begin
                if (i_cpu_req) begin
                    if (w_hit)
                        w_state_nxt = S_RESP;
                    else if (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim])
                        w_state_nxt = S_WB;
                    else
                        w_state_nxt = S_REFILL;
                end
            end
            S_WB: begin
                o_mem_req   = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = (ADDR_W'(r_tag[w_idx][r_victim]) << TAG_LSB) | w_base;
                o_mem_wdata = r_data[w_idx][r_victim][r_beat];
                if (i_mem_ack && w_last)
                    w_state_nxt = S_REFILL;
            end
            S_REFILL: begin
                o_mem_req  = 1'b1;
                o_mem_addr = (ADDR_W'(w_tag) << TAG_LSB) | w_base;
                if (w_fill_done)
                    w_state_nxt = S_RESP;
            end
            S_RESP: begin
                o_cpu_ready   = 1'b1;
                o_hit_or_miss = r_hit;
                w_state_nxt   = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_read_data = r_rdata;

    // NOTE: state in always_ff is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // NOTE: data and tag arrays carry no reset; the valid bits alone decide whether their contents mean anything.
    always_ff @(posedge i_clk) begin
        if (w_hit_acc && i_read_or_write)
            r_data[w_idx][w_hit_way][w_off] <= i_write_data;
        if (w_refill_we)
            r_data[w_idx][r_victim][r_beat] <= (i_read_or_write && r_beat == w_off) ? i_write_data : i_mem_rdata;
        if (w_fill_done)
            r_tag[w_idx][r_victim] <= w_tag;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                // Ages start as a permutation so the LRU ordering is total from the first access.
                for (int w = 0; w < WAYS; w++)
                    r_age[s][w] <= WAY_W'(w);
            end
            r_beat   <= '0;
            r_victim <= '0;
            r_rdata  <= '0;
            r_hit    <= 1'b0;
        end else begin
            if (w_miss_start) begin
                r_victim                   <= w_victim;
                r_beat                     <= '0;
                r_hit                      <= 1'b0;
                // The victim stops being valid while its block is being replaced.
                r_valid[w_idx][w_victim]   <= 1'b0;
                r_dirty[w_idx][w_victim]   <= 1'b0;
            end
            if ((r_state == S_WB || r_state == S_REFILL) && i_mem_ack)
                r_beat <= w_last ? '0 : r_beat + 1'b1;
            if (w_hit_acc) begin
                r_hit   <= 1'b1;
                r_rdata <= i_read_or_write ? i_write_data : r_data[w_idx][w_hit_way][w_off];
                if (i_read_or_write)
                    r_dirty[w_idx][w_hit_way] <= 1'b1;
            end
            if (w_fill_done) begin
                r_valid[w_idx][r_victim] <= 1'b1;
                r_dirty[w_idx][r_victim] <= i_read_or_write;
                if (i_read_or_write)
                    r_rdata <= i_write_data;
                else if (r_beat == w_off)
                    r_rdata <= i_mem_rdata;
                else
                    r_rdata <= r_data[w_idx][r_victim][w_off];
            end
            if (w_acc_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == w_acc_way)
                        r_age[w_idx][w] <= '0;
                    else if (r_age[w_idx][w] < r_age[w_idx][w_acc_way])
                        r_age[w_idx][w] <= r_age[w_idx][w] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_wb_nway.sv
// Directed bench for cache_wb_nway: instance 0 is a 2-way, 4-set cache and instance 1 is a 4-way, 1-set cache.
// Each instance has its own word-addressed memory model that acks every other cycle and can be told to stall.
module tb_cache_wb_nway;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req, rw, ready, hm, mreq, mwe, ack;
    logic [1:0][9:0]  addr, maddr;
    logic [1:0][31:0] wdata, rdata, mwdata, mrdata;

    logic [31:0] mem [2][256];
    logic [9:0]  log_addr [2][32];
    int          log_n [2]     = '{0, 0};
    int          wb_cnt [2]    = '{0, 0};
    int          rf_cnt [2]    = '{0, 0};
    int          stall_lim [2] = '{1000000, 1000000};
    logic [7:0]  mword;

    int n_checks = 0;
    int n_fail   = 0;

    cache_wb_nway #(.ADDR_W(10), .WORD_W(32), .BLK_WORDS(4), .SETS(4), .WAYS(2)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_cpu_req(req[0]), .i_read_or_write(rw[0]),
        .i_addr(addr[0]), .i_write_data(wdata[0]), .o_read_data(rdata[0]),
        .o_cpu_ready(ready[0]), .o_hit_or_miss(hm[0]), .o_mem_req(mreq[0]),
        .o_mem_we(mwe[0]), .o_mem_addr(maddr[0]), .o_mem_wdata(mwdata[0]),
        .i_mem_rdata(mrdata[0]), .i_mem_ack(ack[0])
    );

    cache_wb_nway #(.ADDR_W(10), .WORD_W(32), .BLK_WORDS(4), .SETS(1), .WAYS(4)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_cpu_req(req[1]), .i_read_or_write(rw[1]),
        .i_addr(addr[1]), .i_write_data(wdata[1]), .o_read_data(rdata[1]),
        .o_cpu_ready(ready[1]), .o_hit_or_miss(hm[1]), .o_mem_req(mreq[1]),
        .o_mem_we(mwe[1]), .o_mem_addr(maddr[1]), .o_mem_wdata(mwdata[1]),
        .i_mem_rdata(mrdata[1]), .i_mem_ack(ack[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Memory model: word k holds 0 for k<4, else 0xA0000000|k. Acks one beat every other cycle.
    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 256; i++)
                mem[k][i] = (i < 4) ? 32'h0 : (32'hA000_0000 | 32'(i));
        ack    = '0;
        mrdata = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (ack[k] || !mreq[k]) begin
                    ack[k] = 1'b0;
                end else if (mwe[k] || rf_cnt[k] < stall_lim[k]) begin
                    ack[k] = 1'b1;
                    mword  = maddr[k][9:2];
                    log_addr[k][log_n[k] % 32] = maddr[k];
                    log_n[k]++;
                    if (mwe[k]) begin
                        mem[k][mword] = mwdata[k];
                        wb_cnt[k]++;
                    end else begin
                        mrdata[k] = mem[k][mword];
                        rf_cnt[k]++;
                    end
                end
            end
        end
    end

    typedef struct {
        int          inst;
        logic        rw;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic        exp_hit;
        logic        chk_rd;
        logic [31:0] exp_rd;
        int          exp_wb;
        int          exp_rf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic access(input int k, input logic w, input logic [9:0] a, input logic [31:0] d,
                          output logic ok, output logic hit_o, output logic [31:0] rd_o, output int cyc);
        @(negedge clk);
        req[k]   = 1'b1;
        rw[k]    = w;
        addr[k]  = a;
        wdata[k] = d;
        ok = 1'b0; hit_o = 1'b0; rd_o = '0; cyc = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (ready[k]) begin
                ok = 1'b1; hit_o = hm[k]; rd_o = rdata[k]; cyc = c;
                break;
            end
        end
        @(negedge clk);
        req[k] = 1'b0;
    endtask

    task automatic run_vec(input int i);
        vec_t        v;
        int          wb0, rf0, cyc;
        logic        ok, hit;
        logic [31:0] rd;
        v   = vecs[i];
        wb0 = wb_cnt[v.inst];
        rf0 = rf_cnt[v.inst];
        access(v.inst, v.rw, v.addr, v.wdata, ok, hit, rd, cyc);
        check($sformatf("v%0d ready", i), 32'(ok), 32'd1);
        if (ok) begin
            check($sformatf("v%0d hit", i), 32'(hit), 32'(v.exp_hit));
            if (v.chk_rd)
                check($sformatf("v%0d rdata", i), rd, v.exp_rd);
            check($sformatf("v%0d wb_beats", i), 32'(wb_cnt[v.inst] - wb0), 32'(v.exp_wb));
            check($sformatf("v%0d refill_beats", i), 32'(rf_cnt[v.inst] - rf0), 32'(v.exp_rf));
            if (v.exp_hit)
                check($sformatf("v%0d hit_latency", i), 32'(cyc), 32'd1);
        end
    endtask

    initial begin
        int   n;
        logic got;
        rst_n = 1'b0;
        req = '0; rw = '0; addr = '0; wdata = '0;

        //             inst rw addr    wdata         hit chk rdata         wb rf
        vecs.push_back('{0, 0, 10'h000, 32'h0,        0, 1, 32'h0000_0000, 0, 4});
        vecs.push_back('{0, 1, 10'h000, 32'h0000_00FF, 1, 0, 32'h0,        0, 0});
        vecs.push_back('{0, 0, 10'h000, 32'h0,        1, 1, 32'h0000_00FF, 0, 0});
        vecs.push_back('{0, 0, 10'h200, 32'h0,        0, 1, 32'hA000_0080, 0, 4});
        vecs.push_back('{0, 0, 10'h000, 32'h0,        1, 1, 32'h0000_00FF, 0, 0});
        vecs.push_back('{0, 0, 10'h300, 32'h0,        0, 1, 32'hA000_00C0, 0, 4});
        vecs.push_back('{0, 0, 10'h200, 32'h0,        0, 1, 32'hA000_0080, 4, 4});
        vecs.push_back('{0, 0, 10'h304, 32'h0,        1, 1, 32'hA000_00C1, 0, 0});
        vecs.push_back('{0, 1, 10'h014, 32'h1234_5678, 0, 1, 32'h1234_5678, 0, 4});
        vecs.push_back('{0, 0, 10'h014, 32'h0,        1, 1, 32'h1234_5678, 0, 0});
        vecs.push_back('{0, 0, 10'h018, 32'h0,        1, 1, 32'hA000_0006, 0, 0});
        vecs.push_back('{0, 0, 10'h03C, 32'h0,        0, 1, 32'hA000_000F, 0, 4});
        vecs.push_back('{0, 1, 10'h02C, 32'h0000_DEAD, 0, 1, 32'h0000_DEAD, 0, 4});
        vecs.push_back('{0, 0, 10'h02C, 32'h0,        1, 1, 32'h0000_DEAD, 0, 0});
        vecs.push_back('{1, 0, 10'h000, 32'h0,        0, 1, 32'h0000_0000, 0, 4});
        vecs.push_back('{1, 0, 10'h010, 32'h0,        0, 1, 32'hA000_0004, 0, 4});
        vecs.push_back('{1, 0, 10'h020, 32'h0,        0, 1, 32'hA000_0008, 0, 4});
        vecs.push_back('{1, 0, 10'h030, 32'h0,        0, 1, 32'hA000_000C, 0, 4});
        vecs.push_back('{1, 0, 10'h004, 32'h0,        1, 1, 32'h0000_0000, 0, 0});
        vecs.push_back('{1, 0, 10'h014, 32'h0,        1, 1, 32'hA000_0005, 0, 0});
        vecs.push_back('{1, 0, 10'h028, 32'h0,        1, 1, 32'hA000_000A, 0, 0});
        vecs.push_back('{1, 0, 10'h040, 32'h0,        0, 1, 32'hA000_0010, 0, 4});
        vecs.push_back('{1, 0, 10'h00C, 32'h0,        1, 1, 32'h0000_0000, 0, 0});
        vecs.push_back('{1, 0, 10'h01C, 32'h0,        1, 1, 32'hA000_0007, 0, 0});
        vecs.push_back('{1, 0, 10'h02C, 32'h0,        1, 1, 32'hA000_000B, 0, 0});
        vecs.push_back('{1, 0, 10'h030, 32'h0,        0, 1, 32'hA000_000C, 0, 4});
        vecs.push_back('{0, 0, 10'h0C0, 32'h0,        0, 1, 32'hA000_0030, 0, 4});
        vecs.push_back('{0, 0, 10'h304, 32'h0,        0, 1, 32'hA000_00C1, 0, 4});

        repeat (3) @(negedge clk);
        #1;
        check("reset cpu_ready", 32'(ready[0]), 32'd0);
        check("reset hit_or_miss", 32'(hm[0]), 32'd0);
        check("reset read_data", rdata[0], 32'd0);
        check("reset mem_req", 32'(mreq[0]), 32'd0);
        check("reset mem_we", 32'(mwe[0]), 32'd0);
        check("reset mem_addr", 32'(maddr[0]), 32'd0);
        check("reset mem_wdata", mwdata[0], 32'd0);
        check("reset mem_req inst1", 32'(mreq[1]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // T1: first read refills beats 0x000..0x00C in order.
        run_vec(0);
        for (int b = 0; b < 4; b++)
            check($sformatf("t1 refill addr%0d", b), 32'(log_addr[0][b]), 32'(b * 4));

        // T2: write hit stays in the cache only.
        run_vec(1);
        run_vec(2);
        check("t2 mem0 untouched", mem[0][0], 32'h0);

        // T3/T4: fill way 1, evict clean way, then evict dirty 0x000.
        for (int i = 3; i <= 5; i++) run_vec(i);
        n = log_n[0];
        run_vec(6);
        for (int b = 0; b < 4; b++)
            check($sformatf("t4 wb addr%0d", b), 32'(log_addr[0][(n + b) % 32]), 32'(b * 4));
        check("t4 refill after wb", 32'(log_addr[0][(n + 4) % 32]), 32'h200);
        check("t4 mem0 written back", mem[0][0], 32'h0000_00FF);

        // Remaining 2-way vectors and T5 on the 4-way instance.
        for (int i = 7; i <= 25; i++) run_vec(i);

        // T6: stall on the 2nd refill beat, then pulse reset.
        stall_lim[0] = rf_cnt[0] + 1;
        @(negedge clk);
        req[0] = 1'b1; rw[0] = 1'b0; addr[0] = 10'h0C0;
        got = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (rf_cnt[0] == stall_lim[0]) begin
                got = 1'b1;
                break;
            end
        end
        check("t6 first beat seen", 32'(got), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("t6 stalled mem_req", 32'(mreq[0]), 32'd1);
        check("t6 stalled mem_addr", 32'(maddr[0]), 32'h0C4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6 mem_req drops", 32'(mreq[0]), 32'd0);
        check("t6 cpu_ready low", 32'(ready[0]), 32'd0);
        @(negedge clk);
        req[0] = 1'b0;
        stall_lim[0] = 1000000;
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(26);
        run_vec(27);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
